// File: rtl/axi_lite_rom_reader.sv
// axi_lite_rom_reader: AXI4-lite read master that streams COUNT consecutive registers from a slave
module axi_lite_rom_reader #(
  parameter int C_M_AXI_ADDR_WIDTH = 12,
  parameter int C_M_AXI_DATA_WIDTH = 128,
  parameter int REG_DATA_WIDTH = 64,
  parameter int MAX_COUNT = 16,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic M_AXI_ACLK_i,
  input  logic M_AXI_ARESET_i,
  input  logic start_i,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] base_addr_i,
  input  logic [$clog2(MAX_COUNT+1)-1:0] count_i,
  output logic busy_o,
  output logic done_o,
  output logic error_o,
  output logic [$clog2(MAX_COUNT)-1:0] err_index_o,
  output logic timeout_o,
  output logic [REG_DATA_WIDTH-1:0] data_o,
  output logic [$clog2(MAX_COUNT)-1:0] data_index_o,
  output logic data_valid_o,
  input  logic data_ready_i,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR_o,
  output logic M_AXI_ARVALID_o,
  input  logic M_AXI_ARREADY_i,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA_i,
  input  logic [1:0] M_AXI_RRESP_i,
  input  logic M_AXI_RVALID_i,
  output logic M_AXI_RREADY_o
);
  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int RW = REG_DATA_WIDTH;
  localparam int IW = $clog2(MAX_COUNT);
  localparam int CW = $clog2(MAX_COUNT + 1);
  localparam int SB = $clog2(RW / 8);
  localparam int LANES = C_M_AXI_DATA_WIDTH / RW;
  localparam int LW = LANES > 1 ? $clog2(LANES) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, ADDR, DATA, DRAIN} state_t;
  state_t state;
  logic [IW-1:0] idx;
  logic [CW-1:0] cnt, count_sat;
  logic [TW-1:0] wd;
  logic [LW-1:0] lane;
  logic r_hs, stall;
  assign count_sat = count_i > CW'(MAX_COUNT) ? CW'(MAX_COUNT) : count_i;
  assign lane = LANES > 1 ? LW'(M_AXI_ARADDR_o >> SB) : '0;
  assign M_AXI_RREADY_o = state == DATA && !data_valid_o;
  assign r_hs = M_AXI_RVALID_i && M_AXI_RREADY_o;
  // Backpressured DATA waits (RREADY low) do not count toward the watchdog
  assign stall = (state == ADDR && !M_AXI_ARREADY_i) || (state == DATA && M_AXI_RREADY_o && !M_AXI_RVALID_i);
  always_ff @(posedge M_AXI_ACLK_i) begin
    if (M_AXI_ARESET_i) begin
      state <= IDLE;
      idx <= '0;
      cnt <= '0;
      wd <= '0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      error_o <= 1'b0;
      err_index_o <= '0;
      timeout_o <= 1'b0;
      data_o <= '0;
      data_index_o <= '0;
      data_valid_o <= 1'b0;
      M_AXI_ARADDR_o <= '0;
      M_AXI_ARVALID_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (data_valid_o && data_ready_i) data_valid_o <= 1'b0;
      if (stall && wd != TW'(TIMEOUT_CYCLES)) wd <= wd + 1'b1;
      if (stall && wd == TW'(TIMEOUT_CYCLES - 1)) timeout_o <= 1'b1;
      case (state)
        IDLE: if (start_i) begin
          error_o <= 1'b0;
          timeout_o <= 1'b0;
          if (count_sat == '0) done_o <= 1'b1;
          else begin
            busy_o <= 1'b1;
            cnt <= count_sat;
            idx <= '0;
            wd <= '0;
            M_AXI_ARADDR_o <= base_addr_i & ~AW'((1 << SB) - 1);
            M_AXI_ARVALID_o <= 1'b1;
            state <= ADDR;
          end
        end
        ADDR: if (M_AXI_ARREADY_i) begin
          M_AXI_ARVALID_o <= 1'b0;
          wd <= '0;
          state <= DATA;
        end
        DATA: if (r_hs) begin
          wd <= '0;
          data_o <= M_AXI_RDATA_i[lane*RW +: RW];
          data_index_o <= idx;
          data_valid_o <= 1'b1;
          if (M_AXI_RRESP_i != 2'b00 && !error_o) begin
            error_o <= 1'b1;
            err_index_o <= idx;
          end
          if (CW'(idx) == cnt - 1'b1) state <= DRAIN;
          else begin
            idx <= idx + 1'b1;
            M_AXI_ARADDR_o <= M_AXI_ARADDR_o + AW'(RW / 8);
            M_AXI_ARVALID_o <= 1'b1;
            state <= ADDR;
          end
        end
        DRAIN: if (!data_valid_o) begin
          done_o <= 1'b1;
          busy_o <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_lite_rom_reader.sv
// tb_axi_lite_rom_reader: randomized ROM-slave bench with a register-level scoreboard
module tb_axi_lite_rom_reader;
  logic clk, rst, start, busy, done, error, timeout, dvalid, dready;
  logic arvalid, arready, rvalid, rready;
  logic [11:0] base, araddr;
  logic [4:0] count;
  logic [3:0] err_index, data_index;
  logic [63:0] data;
  logic [127:0] rdata;
  logic [1:0] rresp;
  logic [63:0] rom [512];
  logic [11:0] exp_addr [$];
  logic [63:0] exp_data [$];
  int exp_idx [$];
  int n_chk = 0, n_pass = 0;
  int s_err = -1, ar_blk = 0, rmode = 0, r_fixed = -1, done_cnt = 0, beat_n = 0;
  bit stall_armed = 0;

  axi_lite_rom_reader dut (
    .M_AXI_ACLK_i(clk), .M_AXI_ARESET_i(rst), .start_i(start), .base_addr_i(base), .count_i(count),
    .busy_o(busy), .done_o(done), .error_o(error), .err_index_o(err_index), .timeout_o(timeout),
    .data_o(data), .data_index_o(data_index), .data_valid_o(dvalid), .data_ready_i(dready),
    .M_AXI_ARADDR_o(araddr), .M_AXI_ARVALID_o(arvalid), .M_AXI_ARREADY_i(arready),
    .M_AXI_RDATA_i(rdata), .M_AXI_RRESP_i(rresp), .M_AXI_RVALID_i(rvalid), .M_AXI_RREADY_o(rready)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Slave, stream sink and scoreboard share one negedge process so their ordering is fixed
  initial begin
    int st, aw, rw, stall, wcnt;
    bit rr_prev, hold, seen;
    logic [63:0] hd;
    logic [3:0] hi;
    logic [11:0] cap;
    st = 0; aw = 0; rw = 0; stall = 0; wcnt = 0; rr_prev = 0; hold = 0; seen = 0; hd = '0; hi = '0; cap = '0;
    arready = 0; rvalid = 0; rdata = '0; rresp = '0; dready = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        st = 0; arready = 0; rvalid = 0; rr_prev = 0; hold = 0; stall = 0; wcnt = 0; seen = 0; dready = 0;
        continue;
      end
      if (done) done_cnt++;
      if (hold) begin
        chk("hold_valid", 64'(dvalid), 64'(1));
        chk("hold_data", data, hd);
        chk("hold_idx", 64'(data_index), 64'(hi));
      end
      if (dvalid) chk("rready_bp", 64'(rready), 64'(0));
      if (dvalid && rmode == 2 && stall_armed) begin
        stall = 10;
        stall_armed = 0;
      end
      dready = stall > 0 ? 1'b0 : rmode == 1 ? 1'($urandom % 2) : 1'b1;
      if (stall > 0) stall--;
      hold = dvalid && !dready;
      hd = data;
      hi = data_index;
      if (dvalid && dready) begin
        chk("beat_avail", 64'(exp_data.size() > 0), 64'(1));
        if (exp_data.size() > 0) begin
          chk("beat_data", data, exp_data.pop_front());
          chk("beat_idx", 64'(data_index), 64'(exp_idx.pop_front()));
        end
      end
      if (st == 0) begin
        if (arready) begin
          arready = 0;
          st = 1;
          rw = r_fixed >= 0 ? r_fixed : int'($urandom % 3);
          seen = 0;
          wcnt = 0;
        end else if (arvalid || seen) begin
          if (seen) chk("arvalid_held", 64'(arvalid), 64'(1));
          if (ar_blk > 0) begin
            if (wcnt == 255 || wcnt == 256)
              chk(wcnt == 255 ? "timeout_w255" : "timeout_w256", 64'(timeout), 64'(wcnt >= 256));
            ar_blk--;
            wcnt++;
            seen = 1;
          end else if (aw > 0) aw--;
          else begin
            arready = 1;
            cap = araddr;
            chk("ar_avail", 64'(exp_addr.size() > 0), 64'(1));
            if (exp_addr.size() > 0) chk("araddr", 64'(araddr), 64'(exp_addr.pop_front()));
          end
        end
      end else if (rvalid && rr_prev) begin
        rvalid = 0;
        st = 0;
        aw = int'($urandom % 3);
      end else if (!rvalid) begin
        if (rw > 0) rw--;
        else begin
          rvalid = 1;
          rdata = {rom[{cap[11:4], 1'b1}], rom[{cap[11:4], 1'b0}]};
          rresp = beat_n == s_err ? 2'd2 : 2'd0;
          beat_n++;
        end
      end
      rr_prev = rready;
    end
  end

  task automatic expect_seq(input logic [11:0] b, input int n);
    logic [11:0] a;
    exp_addr.delete();
    exp_data.delete();
    exp_idx.delete();
    for (int k = 0; k < n; k++) begin
      a = (b & 12'hFF8) + 12'(8 * k);
      exp_addr.push_back(a);
      exp_data.push_back(rom[a[11:3]]);
      exp_idx.push_back(k);
    end
  endtask

  task automatic run(input logic [11:0] b, input int c, input int err, input int blk, input int rm, input bit mid);
    int n;
    n = c > 16 ? 16 : c;
    expect_seq(b, n);
    beat_n = 0; s_err = err; ar_blk = blk; rmode = rm; stall_armed = rm == 2; done_cnt = 0;
    start = 1; base = b; count = 5'(c);
    @(negedge clk);
    start = 0;
    if (n > 0) chk("busy", 64'(busy), 64'(1));
    if (mid) begin
      repeat (3) @(negedge clk);
      start = 1; base = 12'($urandom); count = 5'($urandom);
      @(negedge clk);
      start = 0;
    end
    for (int i = 0; i < 3000 && done_cnt == 0; i++) @(negedge clk);
    @(negedge clk);
    chk("done_once", 64'(done_cnt), 64'(1));
    chk("busy_end", 64'(busy), 64'(0));
    chk("beats_left", 64'(exp_data.size()), 64'(0));
    chk("ar_left", 64'(exp_addr.size()), 64'(0));
    chk("error", 64'(error), 64'(err >= 0 && err < n));
    if (err >= 0 && err < n) chk("err_index", 64'(err_index), 64'(err));
    chk("timeout", 64'(timeout), 64'(blk >= 256));
  endtask

  task automatic check_reset_outs();
    chk("rst_ctrl", 64'({busy, done, error, err_index, timeout, dvalid, data_index, arvalid, rready}), 64'(0));
    chk("rst_data", data, 64'(0));
    chk("rst_addr", 64'(araddr), 64'(0));
  endtask

  initial begin
    rst = 1; start = 0; base = '0; count = '0;
    for (int k = 0; k < 512; k++) rom[k] = 64'h1000 + 64'(k);
    repeat (3) @(negedge clk);
    check_reset_outs();
    rst = 0;
    @(negedge clk);
    run(12'h000, 4, -1, 0, 0, 0);
    for (int k = 0; k < 512; k++) rom[k] = {$urandom, $urandom};
    run(12'h00B, 2, -1, 0, 0, 0);
    run(12'hFF8, 2, -1, 0, 0, 0);
    run(12'h100, 4, -1, 0, 2, 0);
    run(12'h040, 5, 2, 0, 0, 0);
    start = 1; count = 0;
    @(negedge clk);
    start = 0;
    chk("cnt0_done", 64'(done), 64'(1));
    chk("cnt0_busy", 64'(busy), 64'(0));
    chk("cnt0_err_clr", 64'(error), 64'(0));
    chk("cnt0_arvalid", 64'(arvalid), 64'(0));
    @(negedge clk);
    chk("cnt0_done_end", 64'(done), 64'(0));
    chk("cnt0_arvalid2", 64'(arvalid), 64'(0));
    run(12'h200, 3, -1, 300, 0, 0);
    run(12'h208, 2, -1, 0, 1, 0);
    run(12'h300, 6, -1, 0, 1, 1);
    expect_seq(12'h400, 1);
    r_fixed = 20; rmode = 0; s_err = -1; ar_blk = 0;
    start = 1; base = 12'h400; count = 5'd4;
    @(negedge clk);
    start = 0;
    for (int i = 0; i < 50 && !rready; i++) @(negedge clk);
    chk("reach_data", 64'(rready), 64'(1));
    rst = 1;
    @(negedge clk);
    check_reset_outs();
    rst = 0;
    r_fixed = -1;
    expect_seq(12'h000, 0);
    @(negedge clk);
    for (int t = 0; t < 12; t++)
      run(12'($urandom), int'($urandom % 20), ($urandom % 3 == 0) ? int'($urandom % 16) : -1, 0, int'($urandom % 3), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
